// File: rtl/pipe_pkg.sv
// Shared types, widths and hazard-detection helper for the pipeline hazard controller.
// The pipe_perf_cnt counter widths are used only when PIPE_PERF_CNT_EN is defined.
package pipe_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned SEQ_CNT_W   = 4;
    localparam int unsigned CYCLE_CNT_W = 32;
    localparam int unsigned EVT_CNT_W   = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hz_state_e;

    function automatic logic is_load_use(
        input logic             mem_read,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic             uses_rs2
    );
        return mem_read && (rd != '0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Performance counters for pipe_hazard_ctrl: free-running cycle count plus
// saturating stall and flush event counts. Instantiated only under PIPE_PERF_CNT_EN.
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   count_en,
    input  logic                   stall_evt,
    input  logic                   flush_evt,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt,
    output logic [EVT_CNT_W-1:0]   stall_cnt,
    output logic [EVT_CNT_W-1:0]   flush_cnt
);

    logic [CYCLE_CNT_W-1:0] cycle_q, cycle_d;
    logic [EVT_CNT_W-1:0]   stall_q, stall_d;
    logic [EVT_CNT_W-1:0]   flush_q, flush_d;

    always_comb begin
        cycle_d = cycle_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (count_en) begin
            cycle_d = cycle_q + CYCLE_CNT_W'(1);
        end
        if (stall_evt && (stall_q != '1)) begin
            stall_d = stall_q + EVT_CNT_W'(1);
        end
        if (flush_evt && (flush_q != '1)) begin
            flush_d = flush_q + EVT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: mispredict flush, load-use stall, jr flush and halt drain.
// Defining PIPE_PERF_CNT_EN adds the cycle_cnt/stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int HALT_DRAIN     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_D,
    input  logic [REG_W-1:0] rs2_D,
    input  logic             uses_rs2_D,
    input  logic [REG_W-1:0] rd_E,
    input  logic             MemRead_E,
    input  logic             mispredict_E,
    input  logic             jr_D,
    input  logic             halt_D,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             stall_HDU,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             done
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt,
    output logic [EVT_CNT_W-1:0]   stall_cnt,
    output logic [EVT_CNT_W-1:0]   flush_cnt
`endif
);

    hz_state_e            state_q, state_d;
    logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;
    logic                 load_use;

    assign load_use = is_load_use(MemRead_E, rd_E, rs1_D, rs2_D, uses_rs2_D);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        stall_HDU   = 1'b0;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;

        case (state_q)
            RUN: begin
                if (mispredict_E) begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end else if (load_use) begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    stall_HDU   = 1'b1;
                    // The detecting cycle is the first stall cycle; STALL covers the rest.
                    if (LOAD_USE_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = SEQ_CNT_W'(LOAD_USE_STALL - 2);
                    end
                end else if (jr_D) begin
                    flush_IF_ID = 1'b1;
                end else if (halt_D) begin
                    PC_write    = 1'b0;
                    flush_IF_ID = 1'b1;
                    state_d     = DRAIN;
                    cnt_d       = SEQ_CNT_W'(HALT_DRAIN - 1);
                end
            end
            STALL: begin
                if (mispredict_E) begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                    state_d     = RUN;
                    cnt_d       = '0;
                end else begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    stall_HDU   = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - SEQ_CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (mispredict_E) begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                    state_d     = RUN;
                    cnt_d       = '0;
                end else begin
                    PC_write = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - SEQ_CNT_W'(1);
                    end
                end
            end
            DONE: begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                stall_HDU   = 1'b1;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        // RUN outputs depend on live inputs, so hold the idle values while reset is low.
        if (!reset) begin
            PC_write    = 1'b1;
            IF_ID_write = 1'b1;
            stall_HDU   = 1'b0;
            flush_IF_ID = 1'b0;
            flush_ID_EX = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done = (state_q == DONE);

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt u_perf_cnt (
        .clk       (clk),
        .reset     (reset),
        .count_en  (state_q != DONE),
        .stall_evt (stall_HDU && (state_q != DONE)),
        .flush_evt (flush_IF_ID || flush_ID_EX),
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_USE_STALL=2 and =1) driven in parallel
// and checked every cycle against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

    localparam int LUS0 = 2;
    localparam int LUS1 = 1;
    localparam int HD   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs1_D = '0, rs2_D = '0, rd_E = '0;
    logic       uses_rs2_D = 1'b0, MemRead_E = 1'b0, mispredict_E = 1'b0;
    logic       jr_D = 1'b0, halt_D = 1'b0;

    logic [1:0] pc_w, ifid_w, st_w, f1_w, f2_w, dn_w;
`ifdef PIPE_PERF_CNT_EN
    logic [1:0][31:0] cyc_w;
    logic [1:0][15:0] scnt_w, fcnt_w;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_USE_STALL(LUS0), .HALT_DRAIN(HD)) dut0 (
        .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D), .uses_rs2_D(uses_rs2_D),
        .rd_E(rd_E), .MemRead_E(MemRead_E), .mispredict_E(mispredict_E), .jr_D(jr_D),
        .halt_D(halt_D), .PC_write(pc_w[0]), .IF_ID_write(ifid_w[0]), .stall_HDU(st_w[0]),
        .flush_IF_ID(f1_w[0]), .flush_ID_EX(f2_w[0]), .done(dn_w[0])
`ifdef PIPE_PERF_CNT_EN
        , .cycle_cnt(cyc_w[0]), .stall_cnt(scnt_w[0]), .flush_cnt(fcnt_w[0])
`endif
    );

    pipe_hazard_ctrl #(.LOAD_USE_STALL(LUS1), .HALT_DRAIN(HD)) dut1 (
        .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D), .uses_rs2_D(uses_rs2_D),
        .rd_E(rd_E), .MemRead_E(MemRead_E), .mispredict_E(mispredict_E), .jr_D(jr_D),
        .halt_D(halt_D), .PC_write(pc_w[1]), .IF_ID_write(ifid_w[1]), .stall_HDU(st_w[1]),
        .flush_IF_ID(f1_w[1]), .flush_ID_EX(f2_w[1]), .done(dn_w[1])
`ifdef PIPE_PERF_CNT_EN
        , .cycle_cnt(cyc_w[1]), .stall_cnt(scnt_w[1]), .flush_cnt(fcnt_w[1])
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: remaining stall cycles / remaining drain cycles / halted flag.
    bit          m_done [2] = '{0, 0};
    int          m_stall[2] = '{0, 0};
    int          m_drain[2] = '{0, 0};
    int unsigned m_cyc  [2] = '{0, 0};
    int unsigned m_scnt [2] = '{0, 0};
    int unsigned m_fcnt [2] = '{0, 0};
    bit          n_done [2] = '{0, 0};
    int          n_stall[2] = '{0, 0};
    int          n_drain[2] = '{0, 0};
    int unsigned n_cyc  [2] = '{0, 0};
    int unsigned n_scnt [2] = '{0, 0};
    int unsigned n_fcnt [2] = '{0, 0};
    logic        e_pc[2], e_ifid[2], e_st[2], e_f1[2], e_f2[2], e_dn[2];

    function automatic int lus_of(input int i);
        return (i == 0) ? LUS0 : LUS1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic eval_model();
        logic lu;
        lu = MemRead_E && (rd_E != 5'd0) &&
             ((rd_E == rs1_D) || (uses_rs2_D && (rd_E == rs2_D)));
        for (int i = 0; i < 2; i++) begin
            e_pc[i] = 1'b1; e_ifid[i] = 1'b1; e_st[i] = 1'b0;
            e_f1[i] = 1'b0; e_f2[i] = 1'b0; e_dn[i] = m_done[i];
            n_done[i] = m_done[i]; n_stall[i] = m_stall[i]; n_drain[i] = m_drain[i];
            if (!reset) begin
                e_dn[i] = 1'b0;
                n_done[i] = 0; n_stall[i] = 0; n_drain[i] = 0;
                n_cyc[i] = 0; n_scnt[i] = 0; n_fcnt[i] = 0;
            end else begin
                if (m_done[i]) begin
                    e_pc[i] = 1'b0; e_ifid[i] = 1'b0; e_st[i] = 1'b1;
                end else if (m_stall[i] > 0 || m_drain[i] > 0) begin
                    if (mispredict_E) begin
                        e_f1[i] = 1'b1; e_f2[i] = 1'b1;
                        n_stall[i] = 0; n_drain[i] = 0;
                    end else if (m_stall[i] > 0) begin
                        e_pc[i] = 1'b0; e_ifid[i] = 1'b0; e_st[i] = 1'b1;
                        n_stall[i] = m_stall[i] - 1;
                    end else begin
                        e_pc[i] = 1'b0;
                        n_drain[i] = m_drain[i] - 1;
                        if (n_drain[i] == 0) n_done[i] = 1;
                    end
                end else if (mispredict_E) begin
                    e_f1[i] = 1'b1; e_f2[i] = 1'b1;
                end else if (lu) begin
                    e_pc[i] = 1'b0; e_ifid[i] = 1'b0; e_st[i] = 1'b1;
                    n_stall[i] = lus_of(i) - 1;
                end else if (jr_D) begin
                    e_f1[i] = 1'b1;
                end else if (halt_D) begin
                    e_pc[i] = 1'b0; e_f1[i] = 1'b1;
                    n_drain[i] = HD;
                end
                n_cyc[i]  = m_done[i] ? m_cyc[i] : m_cyc[i] + 1;
                n_scnt[i] = (e_st[i] && !m_done[i] && m_scnt[i] < 65535) ? m_scnt[i] + 1 : m_scnt[i];
                n_fcnt[i] = ((e_f1[i] || e_f2[i]) && m_fcnt[i] < 65535) ? m_fcnt[i] + 1 : m_fcnt[i];
            end
        end
    endtask

    task automatic commit_model();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = n_done[i]; m_stall[i] = n_stall[i]; m_drain[i] = n_drain[i];
            m_cyc[i] = n_cyc[i]; m_scnt[i] = n_scnt[i]; m_fcnt[i] = n_fcnt[i];
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("PC_write[%0d]", i),    32'(pc_w[i]),   32'(e_pc[i]));
            chk($sformatf("IF_ID_write[%0d]", i), 32'(ifid_w[i]), 32'(e_ifid[i]));
            chk($sformatf("stall_HDU[%0d]", i),   32'(st_w[i]),   32'(e_st[i]));
            chk($sformatf("flush_IF_ID[%0d]", i), 32'(f1_w[i]),   32'(e_f1[i]));
            chk($sformatf("flush_ID_EX[%0d]", i), 32'(f2_w[i]),   32'(e_f2[i]));
            chk($sformatf("done[%0d]", i),        32'(dn_w[i]),   32'(e_dn[i]));
`ifdef PIPE_PERF_CNT_EN
            chk($sformatf("cycle_cnt[%0d]", i), cyc_w[i],         m_cyc[i]);
            chk($sformatf("stall_cnt[%0d]", i), 32'(scnt_w[i]),   m_scnt[i]);
            chk($sformatf("flush_cnt[%0d]", i), 32'(fcnt_w[i]),   m_fcnt[i]);
`endif
        end
    endtask

    // Advance one edge, then drive new inputs mid-cycle and check before the next edge.
    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic u2, input logic mp,
                        input logic jr, input logic hl);
        @(posedge clk);
        commit_model();
        @(negedge clk);
        MemRead_E = mr; rd_E = rd; rs1_D = r1; rs2_D = r2; uses_rs2_D = u2;
        mispredict_E = mp; jr_D = jr; halt_D = hl;
        #1;
        eval_model();
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_step();
        step(($urandom % 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom % 2) == 0, ($urandom % 8) == 0,
             ($urandom % 6) == 0, ($urandom % 16) == 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        commit_model();
        @(negedge clk);
        reset = 1'b0;
        MemRead_E = 1'b1; rd_E = 5'd3; rs1_D = 5'd3; rs2_D = 5'($urandom_range(0, 3));
        uses_rs2_D = 1'($urandom); mispredict_E = 1'($urandom); jr_D = 1'b1; halt_D = 1'b1;
        #1;
        eval_model();
        commit_model();
        check_all();
        chk("reset_PC_write", 32'(pc_w[0]), 32'd1);
        chk("reset_flush_ID_EX", 32'(f2_w[1]), 32'd0);
        repeat (2) begin
            @(posedge clk);
            commit_model();
            @(negedge clk);
            #1;
            eval_model();
            check_all();
        end
        reset = 1'b1;
        MemRead_E = 1'b0; rd_E = '0; rs1_D = '0; rs2_D = '0; uses_rs2_D = 1'b0;
        mispredict_E = 1'b0; jr_D = 1'b0; halt_D = 1'b0;
        #1;
        eval_model();
        check_all();
    endtask

    initial begin
        do_reset();

        // Load-use with LOAD_USE_STALL=2 on dut0: two stall cycles, then RUN.
        step(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_c1_PC_write", 32'(pc_w[0]), 32'd0);
        chk("lu_c1_stall", 32'(st_w[0]), 32'd1);
        idle();
        chk("lu_c2_stall", 32'(st_w[0]), 32'd1);
        chk("lu1_back_run", 32'(st_w[1]), 32'd0);
        idle();
        chk("lu_c3_stall", 32'(st_w[0]), 32'd0);
        chk("lu_c3_PC_write", 32'(pc_w[0]), 32'd1);

        // rd_E=0 never produces a hazard; rs2 match only when rs2 is used.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rd0_no_stall", 32'(st_w[0]), 32'd0);
        step(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        // Mispredict outranks a simultaneous load-use.
        step(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("mp_lu_flush_ID_EX", 32'(f2_w[0]), 32'd1);
        chk("mp_lu_stall", 32'(st_w[0]), 32'd0);
        idle();
        chk("mp_lu_no_stall_after", 32'(st_w[0]), 32'd0);

        // Halt: done rises after the 5th edge and holds regardless of inputs.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            idle();
            chk($sformatf("drain_edge%0d_done", k), 32'(dn_w[0]), 32'd0);
        end
        idle();
        chk("done_after_5_edges", 32'(dn_w[0]), 32'd1);
        repeat (4) rand_step();
        chk("done_sticky", 32'(dn_w[1]), 32'd1);
        do_reset();

        // Mispredict on the second drain cycle aborts the drain.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("drain_mp_flush_IF_ID", 32'(f1_w[0]), 32'd1);
        chk("drain_mp_PC_write", 32'(pc_w[0]), 32'd1);
        repeat (5) idle();
        chk("drain_abort_done", 32'(dn_w[0]), 32'd0);

        // Reset in the middle of a stall and of a drain leaves nothing behind.
        step(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("rst_mid_stall", 32'(st_w[0]), 32'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        do_reset();
        idle();
        chk("rst_mid_drain_PC_write", 32'(pc_w[1]), 32'd1);

        // Three load-use stalls and two jr flushes on dut1.
        do_reset();
        repeat (3) begin
            step(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            idle();
        end
        repeat (2) begin
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            idle();
        end
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall_cnt", 32'(scnt_w[1]), 32'd3);
        chk("perf_flush_cnt", 32'(fcnt_w[1]), 32'd2);
`endif

        for (int n = 0; n < 400; n++) begin
            if ((m_done[0] && m_done[1]) || ($urandom % 64) == 0) begin
                do_reset();
            end else begin
                rand_step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_USE_STALL, default 1, meaning stall cycles per load-use hazard (1..7).
REQ-002 SHALL have parameter HALT_DRAIN, default 4, meaning cycles to drain the pipeline after halt (1..15).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports rs1_D and rs2_D, input, 5 each, the decode-stage source registers.
REQ-006 SHALL have port uses_rs2_D, input, 1, set when the decode-stage instruction reads rs2.
REQ-007 SHALL have ports rd_E (input, 5) and MemRead_E (input, 1), the EX-stage destination and its load flag.
REQ-008 SHALL have port mispredict_E, input, 1, set when the EX-stage branch outcome differs from its prediction.
REQ-009 SHALL have ports jr_D and halt_D, input, 1 each, set for a decode-stage jump-register or halt.
REQ-010 SHALL have ports PC_write and IF_ID_write, output, 1 each, the fetch and IF/ID register enables.
REQ-011 SHALL have port stall_HDU, output, 1, which inserts a bubble into ID/EX.
REQ-012 SHALL have ports flush_IF_ID and flush_ID_EX, output, 1 each, which clear those pipeline registers.
REQ-013 SHALL have port done, output, 1, a sticky flag meaning the pipeline has halted.

Function
REQ-014 SHALL implement the states RUN, STALL, DRAIN and DONE.
REQ-015 SHALL define load-use as MemRead_E & rd_E!=0 & (rd_E==rs1_D | (uses_rs2_D & rd_E==rs2_D)).
REQ-016 In RUN, SHALL apply event priority mispredict_E > load-use > jr_D > halt_D, and SHALL act on only one event per cycle.
REQ-017 SHALL, for mispredict_E in RUN, assert flush_IF_ID=1 and flush_ID_EX=1 in the same cycle and stay in RUN.
REQ-018 SHALL, for load-use in RUN, drive PC_write=0, IF_ID_write=0 and stall_HDU=1 in the same cycle.
REQ-019 SHALL, when LOAD_USE_STALL>1, then enter STALL for LOAD_USE_STALL-1 further cycles with the same outputs, and return to RUN.
REQ-020 SHALL, for jr_D in RUN, assert flush_IF_ID=1 for one cycle only.
REQ-021 SHALL, for halt_D in RUN, drive PC_write=0 and flush_IF_ID=1 and enter DRAIN with its counter loaded to HALT_DRAIN-1.
REQ-022 In DRAIN, SHALL hold PC_write=0, decrement the counter each cycle, and enter DONE after the cycle in which the counter is 0.
REQ-023 SHALL, for mispredict_E in STALL or DRAIN, abort the sequence, flush both registers, restore PC_write=1 and return to RUN.
REQ-024 In DONE, SHALL drive PC_write=0, IF_ID_write=0, stall_HDU=1 and done=1, and ignore all inputs until reset.
REQ-025 In RUN with no event, SHALL drive PC_write=1, IF_ID_write=1, and all other outputs 0.

Reset
REQ-026 SHALL, on reset low, immediately enter RUN, clear all counters, and drive PC_write=1, IF_ID_write=1, stall_HDU=0, both flushes 0 and done=0.
REQ-027 SHALL, when reset is asserted mid-STALL or mid-DRAIN, abandon the sequence with no residual stall after release.

Configuration
REQ-028 SHALL, with PIPE_PERF_CNT_EN defined, add output cycle_cnt (32 bits), counting cycles out of reset and frozen in DONE.
REQ-029 SHALL, with PIPE_PERF_CNT_EN defined, add outputs stall_cnt (16, cycles with stall_HDU=1 outside DONE) and flush_cnt (16, cycles with any flush asserted), both saturating at all-ones.
REQ-030 SHALL, without PIPE_PERF_CNT_EN, omit these ports and counters entirely, with all other behaviour identical.

Structure
REQ-031 SHALL take the state enum type, the register-index width (5) and the counter widths from the shared package pipe_pkg.
REQ-032 SHALL place the saturating counters in one sub-module, pipe_perf_cnt, instantiated only under PIPE_PERF_CNT_EN.

Verification
REQ-033 SHALL cover MemRead_E=1, rd_E=8, rs1_D=8, LOAD_USE_STALL=2 -> PC_write=0 and stall_HDU=1 for exactly 2 cycles, then RUN.
REQ-034 SHALL cover rd_E=0 with MemRead_E=1 and rs1_D=0 -> no stall.
REQ-035 SHALL cover load-use together with mispredict_E in the same cycle -> both flushes=1, stall_HDU=0, no STALL entry.
REQ-036 SHALL cover halt_D with HALT_DRAIN=4 -> done=1 on the 5th edge after halt, held until reset.
REQ-037 SHALL cover mispredict_E on the 2nd DRAIN cycle -> both flushes=1, RUN restored, done stays 0.
REQ-038 SHALL cover PIPE_PERF_CNT_EN with 3 load-use stalls plus 2 jr_D -> stall_cnt=3 and flush_cnt=2.
